alsu_result_collector: RTL
==========================

# alsu_result_collector

Downstream consumer of the ALSU output stage: samples the ALSU's registered `out`/`leds` together with the opcode that produced them, buffers each sample in a small FIFO, and hands it to a downstream reader over a valid/ready handshake. It classifies each sample as good or error. In stats builds it also keeps a saturating error count and a running sum of good results. It decouples the free-running ALSU from a reader that may stall.

## Interface
Parameters:
- `DEPTH`, 8: FIFO entries; power of two, ≥2.
- `CNT_W`, 8: width of `err_count`.
- `ACC_W`, 12: width of the signed running sum `acc`.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  strobe: the ALSU result on `in_out`/`in_leds` is meaningful this cycle.
- `in_opcode`  in  3  opcode that produced the result (OR=0 … ROTATE=5, 6/7 invalid).
- `in_out`  in  6  signed ALSU result.
- `in_leds`  in  16  ALSU leds; nonzero means the ALSU flagged an invalid case.
- `out_valid`  out  1  FIFO head available.
- `out_ready`  in  1  reader accepts head.
- `out_opcode`  out  3  head opcode.
- `out_result`  out  6  signed head result.
- `out_err`  out  1  head classified as error.
- `fifo_count`  out  $clog2(DEPTH)+1  occupancy, 0..DEPTH.
- `overflow`  out  1  sticky: a sample was dropped because the FIFO was full.
- `err_count`  out  CNT_W  saturating count of accepted error samples.
- `acc`  out  ACC_W  signed running sum of accepted good results.

## Operation
- Classification: `err = (in_leds != 0) | (in_opcode == 3'b110) | (in_opcode == 3'b111)`.
- Push: when `in_valid` is high and there is space, write {opcode, result, err} at the write pointer.
- There is space when `fifo_count < DEPTH`, or when the FIFO is full and a pop occurs in the same cycle.
- Drop: when `in_valid` is high and there is no space, the sample is discarded and `overflow` is set to 1. `overflow` is cleared only by `rst`.
- Pop: on a cycle with `out_valid & out_ready`, the read pointer advances. `out_ready` is ignored when empty.
- Head outputs stay stable while `out_valid & !out_ready`.
- Pointers are `$clog2(DEPTH)` bits wide and wrap modulo DEPTH. Occupancy is tracked by `fifo_count`, never by pointer comparison alone.
- Simultaneous push and pop leave `fifo_count` unchanged. Only push increments it; only pop decrements it.
- Stats are updated only on accepted pushes (dropped samples are not counted):
  - When err=1: `err_count` increments, saturating at 2^CNT_W−1.
  - When err=0: `in_out` is sign-extended to ACC_W and added to `acc`, with two's-complement wrap (no saturation).
- Reset values: `out_valid`=0, `fifo_count`=0, `overflow`=0, `err_count`=0, `acc`=0, pointers=0, and `out_opcode`/`out_result`/`out_err`=0.
- Reset mid-operation: the FIFO contents are discarded in the reset cycle. No pop is reported and no push is accepted in that cycle.

## Timing
- Push-to-visible latency is 1 cycle. A sample pushed at edge N makes `out_valid`=1 after edge N; there is no combinational fall-through.
- Pop takes effect at the clock edge. The next entry appears on the head outputs right after that edge.
- `out_valid` is registered (equivalent to `fifo_count != 0`).
- `fifo_count`, `overflow`, `err_count` and `acc` update at the same edge as the push/pop that changes them.
- Sustained throughput is 1 sample per cycle when `out_ready` is held high.

## Configuration
- Macro: `ALSU_RESULT_COLLECTOR_STATS_EN`.
- When defined: the `err_count` and `acc` logic is compiled in as described above.
- When not defined: no counter or adder logic is built, and `err_count` and `acc` are tied to 0.
- The FIFO, `out_err` and `overflow` behave identically in both builds, and all ports exist in both builds.

## Test plan
- Reset then single push: `in_valid`=1 for one cycle with opcode=2, out=−5, leds=0. Next cycle: `out_valid`=1, `out_result`=−5, `out_err`=0, `fifo_count`=1. With `out_ready`=1 → `fifo_count`=0 and `acc`=−5 (stats build).
- Error classification: push opcode=6 with leds=0, then opcode=1 with leds=16'hFFFF. Both heads show `out_err`=1, `err_count`=2, `acc` is unchanged.
- Fill/overflow: `out_ready`=0, 9 pushes with DEPTH=8. `fifo_count`=8, `overflow`=1, the 9th sample is absent, and the drained order matches push order 1..8.
- Full with simultaneous push and pop: with the FIFO full, assert `in_valid` and `out_ready` together. The push is accepted, `fifo_count` stays 8 and `overflow` stays 0.
- Saturation/wrap, with CNT_W=2: 5 error pushes leave `err_count`=3. With ACC_W=6: two good pushes of +31 give `acc`=−2.
- Mid-operation reset: with 5 entries queued, assert `rst` for one cycle together with `in_valid`. Afterwards `out_valid`=0, `fifo_count`=0, `overflow`=0, `err_count`=0 and `acc`=0.

Source files
------------

// File: rtl/alsu_result_collector.sv
// ============================================================================
//  Module   : alsu_result_collector
//  Purpose  : Buffers ALSU output samples in a FIFO with a valid/ready reader
//             port. Build macro ALSU_RESULT_COLLECTOR_STATS_EN adds an error
//             counter and a running sum of good results.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module alsu_result_collector #(
   parameter int DEPTH = 8,
   parameter int CNT_W = 8,
   parameter int ACC_W = 12
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   input  logic [2:0]                 in_opcode,
   input  logic signed [5:0]          in_out,
   input  logic [15:0]                in_leds,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [2:0]                 out_opcode,
   output logic signed [5:0]          out_result,
   output logic                       out_err,
   output logic [$clog2(DEPTH):0]     fifo_count,
   output logic                       overflow,
   output logic [CNT_W-1:0]           err_count,
   output logic signed [ACC_W-1:0]    acc
);

   localparam int PTR_W   = $clog2(DEPTH);
   localparam int OCC_W   = PTR_W + 1;
   localparam int ENTRY_W = 10;
   localparam logic [OCC_W-1:0] FULL_COUNT = OCC_W'(DEPTH);

   logic [ENTRY_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic [OCC_W-1:0]   count_next;
   logic [ENTRY_W-1:0] head;
   logic               sample_err;
   logic               has_space;
   logic               do_push;
   logic               do_pop;
   logic               do_drop;

   assign sample_err = (in_leds != 16'd0) || (in_opcode[2:1] == 2'b11);

   // A full FIFO still accepts a sample when the head leaves in the same cycle.
   assign do_pop    = out_valid && out_ready;
   assign has_space = (fifo_count < FULL_COUNT) || do_pop;
   assign do_push   = in_valid && has_space;
   assign do_drop   = in_valid && !has_space;

   always_comb begin
      count_next = fifo_count;
      case ({do_push, do_pop})
         2'b10:   count_next = fifo_count + OCC_W'(1);
         2'b01:   count_next = fifo_count - OCC_W'(1);
         default: count_next = fifo_count;
      endcase
   end

   always_ff @(posedge clk) begin
      if (do_push && !rst) begin
         mem[wr_ptr] <= {in_opcode, in_out, sample_err};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
         out_valid  <= 1'b0;
         overflow   <= 1'b0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         fifo_count <= count_next;
         out_valid  <= (count_next != '0);
         if (do_drop) begin
            overflow <= 1'b1;
         end
      end
   end

   // Head fields are forced to zero while empty so storage contents never leak.
   assign head       = mem[rd_ptr];
   assign out_opcode = out_valid ? head[9:7] : 3'd0;
   assign out_result = out_valid ? head[6:1] : 6'sd0;
   assign out_err    = out_valid ? head[0]   : 1'b0;

`ifdef ALSU_RESULT_COLLECTOR_STATS_EN
   logic signed [ACC_W-1:0] in_out_ext;

   assign in_out_ext = ACC_W'(in_out);

   always_ff @(posedge clk) begin
      if (rst) begin
         err_count <= '0;
         acc       <= '0;
      end else if (do_push) begin
         if (sample_err) begin
            if (err_count != {CNT_W{1'b1}}) begin
               err_count <= err_count + CNT_W'(1);
            end
         end else begin
            acc <= acc + in_out_ext;
         end
      end
   end
`else
   assign err_count = '0;
   assign acc       = '0;
`endif

endmodule

`default_nettype wire
